// File: rtl/branch_pc_unit.sv
// Branch/jump resolution and fetch PC sequencer.
// The execute stage reports control-flow info. This block steers the fetch address.
// It raises a one-cycle flush on redirect, and it traps on a misaligned target.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ex_valid_i,
  input  logic        stall_i,
  input  logic        br_en_i,
  input  logic        cmp_r_i,
  input  logic        jal_i,
  input  logic        jalr_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs1_i,
  input  logic        fetch_ready_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_pc_o,
  output logic [31:0] link_o,
  output logic        flush_o,
  output logic        trap_o,
  output logic [31:0] trap_pc_o,
  output logic [31:0] taken_cnt_o
);

  typedef enum logic [1:0] {BOOT, RUN, REDIRECT, TRAP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        flush_q, flush_d;
  logic        trap_q, trap_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic [31:0] cnt_q, cnt_d;

  logic        resolve, taken, misaligned;
  logic [31:0] jalr_sum, target;

  // Resolve control flow and pick the redirect target (JALR > JAL > branch)
  always_comb begin
    resolve    = ex_valid_i & ~stall_i;
    taken      = resolve & (jalr_i | jal_i | (br_en_i & cmp_r_i));
    jalr_sum   = rs1_i + imm_i;
    target     = jalr_i ? {jalr_sum[31:1], 1'b0} : (ex_pc_i + imm_i);
    misaligned = taken & (target[1:0] != 2'b00);
  end

  // Next-state, next-PC and registered-output computation
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    flush_d   = 1'b0;
    trap_d    = trap_q;
    trap_pc_d = trap_pc_q;
    cnt_d     = cnt_q;
    case (state_q)
      BOOT:     state_d = RUN;
      RUN:      if (fetch_valid_q && fetch_ready_i) pc_d = pc_q + 32'd4;
      REDIRECT: state_d = RUN;
      default:  state_d = TRAP;
    endcase
    // A taken instruction overrides any same-cycle handshake; TRAP ignores everything
    if (state_q != TRAP && taken) begin
      flush_d = 1'b1;
      if (misaligned) begin
        state_d   = TRAP;
        pc_d      = pc_q;
        trap_d    = 1'b1;
        trap_pc_d = ex_pc_i;
      end else begin
        state_d   = REDIRECT;
        pc_d      = target;
        cnt_d     = cnt_q + 32'd1;
      end
    end
    fetch_valid_d = (state_d == RUN);
  end

  // State and output registers, cleared asynchronously by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      trap_q        <= 1'b0;
      trap_pc_q     <= 32'd0;
      cnt_q         <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      trap_q        <= trap_d;
      trap_pc_q     <= trap_pc_d;
      cnt_q         <= cnt_d;
    end
  end

  assign fetch_valid_o = fetch_valid_q;
  assign fetch_pc_o    = pc_q;
  assign link_o        = ex_pc_i + 32'd4;
  assign flush_o       = flush_q;
  assign trap_o        = trap_q;
  assign trap_pc_o     = trap_pc_q;
  assign taken_cnt_o   = cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed testbench for branch_pc_unit with hand-computed expectations.
module tb_branch_pc_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ex_valid_i, stall_i, br_en_i, cmp_r_i, jal_i, jalr_i;
  logic [31:0] ex_pc_i, imm_i, rs1_i;
  logic        fetch_ready_i;
  logic        fetch_valid_o, flush_o, trap_o;
  logic [31:0] fetch_pc_o, link_o, trap_pc_o, taken_cnt_o;

  int n_checks = 0;
  int n_fails  = 0;

  branch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid_i), .stall_i(stall_i), .br_en_i(br_en_i),
    .cmp_r_i(cmp_r_i), .jal_i(jal_i), .jalr_i(jalr_i),
    .ex_pc_i(ex_pc_i), .imm_i(imm_i), .rs1_i(rs1_i),
    .fetch_ready_i(fetch_ready_i),
    .fetch_valid_o(fetch_valid_o), .fetch_pc_o(fetch_pc_o), .link_o(link_o),
    .flush_o(flush_o), .trap_o(trap_o), .trap_pc_o(trap_pc_o),
    .taken_cnt_o(taken_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then sample 1 time unit later
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid_i = 0; stall_i = 0; br_en_i = 0; cmp_r_i = 0; jal_i = 0; jalr_i = 0;
  endtask

  task automatic chk_out(input string tag, input logic fv, input logic [31:0] pc,
                         input logic fl, input logic [31:0] cnt);
    check({tag, ".fv"},    {31'd0, fetch_valid_o}, {31'd0, fv});
    check({tag, ".pc"},    fetch_pc_o, pc);
    check({tag, ".flush"}, {31'd0, flush_o}, {31'd0, fl});
    check({tag, ".cnt"},   taken_cnt_o, cnt);
  endtask

  initial begin
    rst_ni = 0; clear_ex(); fetch_ready_i = 1;
    ex_pc_i = 32'h100; imm_i = 0; rs1_i = 0;
    #3;
    chk_out("reset", 0, 32'h0, 0, 0);
    check("reset.trap", {31'd0, trap_o}, 32'd0);
    check("reset.trap_pc", trap_pc_o, 32'd0);
    check("link", link_o, 32'h104);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1;

    // sequential fetch after BOOT
    step(); chk_out("seq0", 1, 32'h0, 0, 0);
    step(); chk_out("seq1", 1, 32'h4, 0, 0);
    step(); chk_out("seq2", 1, 32'h8, 0, 0);
    step(); chk_out("seq3", 1, 32'hC, 0, 0);

    // taken backward branch: 0x100 + (-16) = 0xF0
    ex_valid_i = 1; br_en_i = 1; cmp_r_i = 1; ex_pc_i = 32'h100; imm_i = 32'hFFFF_FFF0;
    step(); clear_ex(); chk_out("br_taken", 0, 32'hF0, 1, 1);
    step(); chk_out("br_run", 1, 32'hF0, 0, 1);
    step(); chk_out("br_next", 1, 32'hF4, 0, 1);

    // not-taken branch
    ex_valid_i = 1; br_en_i = 1; cmp_r_i = 0;
    step(); clear_ex(); chk_out("br_nt", 1, 32'hF8, 0, 1);

    // aligned JALR: (0x2001 + 3) & ~1 = 0x2004
    ex_valid_i = 1; jalr_i = 1; rs1_i = 32'h2001; imm_i = 32'h3; ex_pc_i = 32'h200;
    step(); clear_ex(); chk_out("jalr", 0, 32'h2004, 1, 2);
    step(); chk_out("jalr_run", 1, 32'h2004, 0, 2);

    // JAL + branch held under stall for 3 cycles, then released
    ex_valid_i = 1; jal_i = 1; br_en_i = 1; cmp_r_i = 1; stall_i = 1;
    ex_pc_i = 32'h300; imm_i = 32'h40;
    step(); chk_out("stall0", 1, 32'h2008, 0, 2);
    step(); chk_out("stall1", 1, 32'h200C, 0, 2);
    step(); chk_out("stall2", 1, 32'h2010, 0, 2);
    stall_i = 0;
    step(); clear_ex(); chk_out("jal", 0, 32'h340, 1, 3);
    step(); chk_out("jal_run", 1, 32'h340, 0, 3);

    // fetch backpressure holds the PC
    fetch_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      step(); chk_out("bp", 1, 32'h340, 0, 3);
    end
    // taken while the fetch is stalled
    ex_valid_i = 1; br_en_i = 1; cmp_r_i = 1; ex_pc_i = 32'h400; imm_i = 32'h20;
    step(); clear_ex(); fetch_ready_i = 1; chk_out("bp_taken", 0, 32'h420, 1, 4);
    step(); chk_out("bp_run", 1, 32'h420, 0, 4);

    // reset in REDIRECT
    ex_valid_i = 1; br_en_i = 1; cmp_r_i = 1; ex_pc_i = 32'h500; imm_i = 32'h8;
    step(); clear_ex(); chk_out("redir", 0, 32'h508, 1, 5);
    #2 rst_ni = 0;
    #1 chk_out("rst_redir", 0, 32'h0, 0, 0);
    @(negedge clk_i); rst_ni = 1;
    step(); chk_out("reboot", 1, 32'h0, 0, 0);
    step(); check("reboot.flush", {31'd0, flush_o}, 32'd0);

    // misaligned JALR: (0x2001 + 1) & ~1 = 0x2002 -> trap
    ex_valid_i = 1; jalr_i = 1; rs1_i = 32'h2001; imm_i = 32'h1; ex_pc_i = 32'h600;
    step(); clear_ex(); chk_out("trap", 0, 32'h4, 1, 0);
    check("trap.trap", {31'd0, trap_o}, 32'd1);
    check("trap.pc", trap_pc_o, 32'h600);
    step(); chk_out("trap_hold", 0, 32'h4, 0, 0);
    // inputs ignored while trapped
    ex_valid_i = 1; br_en_i = 1; cmp_r_i = 1; ex_pc_i = 32'h700; imm_i = 32'h10;
    step(); clear_ex(); chk_out("trap_ign", 0, 32'h4, 0, 0);
    check("trap_ign.trap", {31'd0, trap_o}, 32'd1);
    check("trap_ign.pc", trap_pc_o, 32'h600);

    // reset in TRAP
    #2 rst_ni = 0;
    #1 chk_out("rst_trap", 0, 32'h0, 0, 0);
    check("rst_trap.trap", {31'd0, trap_o}, 32'd0);
    check("rst_trap.pc", trap_pc_o, 32'd0);
    @(negedge clk_i); rst_ni = 1;
    step(); chk_out("reboot2", 1, 32'h0, 0, 0);
    check("reboot2.trap", {31'd0, trap_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
